// File: rtl/dmx3_seq.sv
// dmx3_seq: round-robin three-way demux into held channels A/B/C.
// Optional DMX3_SKIP_BUSY_EN: target search skips full channels.
module dmx3_seq #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESETL,
  input  logic [W-1:0] DIN,
  input  logic         DVALID,
  output logic         DREADY,
  input  logic         SYNC,
  output logic [W-1:0] A_Q,
  output logic [W-1:0] B_Q,
  output logic [W-1:0] C_Q,
  output logic         A_VLD,
  output logic         B_VLD,
  output logic         C_VLD,
  input  logic         A_ACK,
  input  logic         B_ACK,
  input  logic         C_ACK,
  output logic         SEL_0,
  output logic         SEL_1
);

  typedef enum logic [1:0] {
    CH_A = 2'b00,
    CH_B = 2'b01,
    CH_C = 2'b10
  } ch_e;

  ch_e          ptr_q, ptr_d, ptr_n, tgt;
  logic [2:0]   full_q, full_d;
  logic [2:0]   ack, tgt_oh;
  logic [W-1:0] a_q, b_q, c_q;
  logic         rdy, xfer;

  function automatic ch_e nxt(input ch_e p);
    case (p)
      CH_A:    nxt = CH_B;
      CH_B:    nxt = CH_C;
      default: nxt = CH_A;
    endcase
  endfunction

  function automatic logic is_full(input ch_e p,
                                   input logic [2:0] f);
    case (p)
      CH_B:    is_full = f[1];
      CH_C:    is_full = f[2];
      default: is_full = f[0];
    endcase
  endfunction

  assign ack = {C_ACK, B_ACK, A_ACK};

  // Normalise the pointer; the unused code 11 reads as A
  always_comb begin
    case (ptr_q)
      CH_B:    ptr_n = CH_B;
      CH_C:    ptr_n = CH_C;
      default: ptr_n = CH_A;
    endcase
  end

`ifdef DMX3_SKIP_BUSY_EN
  ch_e p1, p2;

  // First free channel starting at the pointer
  always_comb begin
    p1  = nxt(ptr_n);
    p2  = nxt(p1);
    tgt = ptr_n;
    if (!is_full(ptr_n, full_q))
      tgt = ptr_n;
    else if (!is_full(p1, full_q))
      tgt = p1;
    else if (!is_full(p2, full_q))
      tgt = p2;
    rdy = ~&full_q;
  end
`else
  // Strict round-robin: target is the pointer
  always_comb begin
    tgt = ptr_n;
    rdy = ~is_full(ptr_n, full_q);
  end
`endif

  // Target decode and next-state
  always_comb begin
    case (tgt)
      CH_B:    tgt_oh = 3'b010;
      CH_C:    tgt_oh = 3'b100;
      default: tgt_oh = 3'b001;
    endcase
    xfer   = DVALID & rdy;
    full_d = (full_q & ~ack) | (xfer ? tgt_oh : 3'b000);
    if (SYNC)
      ptr_d = CH_A;
    else if (xfer)
      ptr_d = nxt(tgt);
    else
      ptr_d = ptr_n;
  end

  // Pointer, full flags and channel registers
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      ptr_q  <= CH_A;
      full_q <= 3'b000;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
      if (xfer && tgt_oh[0]) a_q <= DIN;
      if (xfer && tgt_oh[1]) b_q <= DIN;
      if (xfer && tgt_oh[2]) c_q <= DIN;
    end
  end

  assign DREADY = rdy;
  assign A_Q    = a_q;
  assign B_Q    = b_q;
  assign C_Q    = c_q;
  assign A_VLD  = full_q[0];
  assign B_VLD  = full_q[1];
  assign C_VLD  = full_q[2];
  assign SEL_0  = (tgt == CH_B);
  assign SEL_1  = (tgt == CH_C);

endmodule

// File: tb/tb_dmx3_seq.sv
// tb_dmx3_seq: directed vectors and sequences for dmx3_seq.
// Checks are table-driven plus a 300-word scoreboard stream.
module tb_dmx3_seq;

  logic       CLK, RESETL;
  logic [7:0] DIN;
  logic       DVALID, DREADY, SYNC;
  logic [7:0] A_Q, B_Q, C_Q;
  logic       A_VLD, B_VLD, C_VLD;
  logic       A_ACK, B_ACK, C_ACK;
  logic       SEL_0, SEL_1;

  int n_cmp = 0;
  int n_bad = 0;

  dmx3_seq #(.W(8)) dut (
    .CLK(CLK), .RESETL(RESETL), .DIN(DIN),
    .DVALID(DVALID), .DREADY(DREADY), .SYNC(SYNC),
    .A_Q(A_Q), .B_Q(B_Q), .C_Q(C_Q),
    .A_VLD(A_VLD), .B_VLD(B_VLD), .C_VLD(C_VLD),
    .A_ACK(A_ACK), .B_ACK(B_ACK), .C_ACK(C_ACK),
    .SEL_0(SEL_0), .SEL_1(SEL_1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic       sync;
    logic [2:0] ack;
    logic       rdy;
    logic [2:0] vld;
    logic [1:0] sel;
    logic [7:0] a, b, c;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%0h req=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] vld3();
    return {C_VLD, B_VLD, A_VLD};
  endfunction

  function automatic logic [1:0] sel2();
    return {SEL_1, SEL_0};
  endfunction

  task automatic idle_in();
    DVALID = 1'b0; DIN = 8'h00; SYNC = 1'b0;
    A_ACK = 1'b0; B_ACK = 1'b0; C_ACK = 1'b0;
  endtask

  // Called just after a posedge; leaves time at posedge+1
  task automatic do_reset();
    idle_in();
    RESETL = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETL = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // One cycle: drive, sample DREADY at negedge, clock
  task automatic cyc(input logic dv, input logic [7:0] d,
                     input logic sy, input logic [2:0] ak,
                     output logic rdy);
    DVALID = dv; DIN = d; SYNC = sy;
    {C_ACK, B_ACK, A_ACK} = ak;
    @(negedge CLK);
    rdy = DREADY;
    @(posedge CLK);
    #1;
    idle_in();
  endtask

  vec_t tbl[8];
  logic r;

  initial begin
    idle_in();
    RESETL = 1'b0;
    #12;
    RESETL = 1'b1;
    @(posedge CLK);
    #1;

    chk("rst_vld", vld3(), 3'b000);
    chk("rst_sel", sel2(), 2'b00);
    chk("rst_rdy", DREADY, 1'b1);
    chk("rst_q", {A_Q, B_Q, C_Q}, 24'h0);

    // fill, then one ACK, then a blocked or skipped write
    tbl[0] = '{1, 8'h11, 0, 3'b000, 1, 3'b001, 2'b01, 8'h11, 8'h00, 8'h00};
    tbl[1] = '{1, 8'h22, 0, 3'b000, 1, 3'b011, 2'b10, 8'h11, 8'h22, 8'h00};
    tbl[2] = '{1, 8'h33, 0, 3'b000, 1, 3'b111, 2'b00, 8'h11, 8'h22, 8'h33};
    tbl[3] = '{0, 8'h00, 0, 3'b000, 0, 3'b111, 2'b00, 8'h11, 8'h22, 8'h33};
`ifdef DMX3_SKIP_BUSY_EN
    tbl[4] = '{0, 8'h00, 0, 3'b010, 0, 3'b101, 2'b01, 8'h11, 8'h22, 8'h33};
    tbl[5] = '{1, 8'h44, 0, 3'b000, 1, 3'b111, 2'b10, 8'h11, 8'h44, 8'h33};
    tbl[6] = '{0, 8'h00, 0, 3'b001, 0, 3'b110, 2'b00, 8'h11, 8'h44, 8'h33};
    tbl[7] = '{1, 8'h45, 0, 3'b000, 1, 3'b111, 2'b01, 8'h45, 8'h44, 8'h33};
`else
    tbl[4] = '{0, 8'h00, 0, 3'b010, 0, 3'b101, 2'b00, 8'h11, 8'h22, 8'h33};
    tbl[5] = '{1, 8'h44, 0, 3'b000, 0, 3'b101, 2'b00, 8'h11, 8'h22, 8'h33};
    tbl[6] = '{1, 8'h44, 0, 3'b001, 0, 3'b100, 2'b00, 8'h11, 8'h22, 8'h33};
    tbl[7] = '{1, 8'h44, 0, 3'b000, 1, 3'b101, 2'b01, 8'h44, 8'h22, 8'h33};
`endif
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].dv, tbl[i].din, tbl[i].sync, tbl[i].ack, r);
      chk($sformatf("tbl%0d_rdy", i), r, tbl[i].rdy);
      chk($sformatf("tbl%0d_vld", i), vld3(), tbl[i].vld);
      chk($sformatf("tbl%0d_sel", i), sel2(), tbl[i].sel);
      chk($sformatf("tbl%0d_q", i), {A_Q, B_Q, C_Q},
          {tbl[i].a, tbl[i].b, tbl[i].c});
    end

    // SYNC on the write of 0x66; A acked on the same cycle
    do_reset();
    cyc(1, 8'h55, 0, 3'b000, r);
    chk("sync_w55_a", A_Q, 8'h55);
    cyc(1, 8'h66, 1, 3'b001, r);
    chk("sync_w66_rdy", r, 1'b1);
    chk("sync_w66_b", B_Q, 8'h66);
    chk("sync_w66_vld", vld3(), 3'b010);
    chk("sync_w66_sel", sel2(), 2'b00);
    cyc(1, 8'h77, 0, 3'b000, r);
    chk("sync_w77_a", A_Q, 8'h77);
    chk("sync_w77_vld", vld3(), 3'b011);
`ifdef DMX3_SKIP_BUSY_EN
    chk("sync_w77_sel", sel2(), 2'b10);
`else
    chk("sync_w77_sel", sel2(), 2'b01);
`endif

    // fill C while acking A; pointer wraps to A
    do_reset();
    cyc(1, 8'h01, 0, 3'b000, r);
    cyc(1, 8'h02, 0, 3'b000, r);
    cyc(1, 8'h03, 0, 3'b001, r);
    chk("wrap_rdy", r, 1'b1);
    chk("wrap_vld", vld3(), 3'b110);
    chk("wrap_sel", sel2(), 2'b00);
    chk("wrap_c", C_Q, 8'h03);
    chk("wrap_rdy_after", DREADY, 1'b1);

    // asynchronous reset with all channels full
    do_reset();
    cyc(1, 8'hA1, 0, 3'b000, r);
    cyc(1, 8'hB2, 0, 3'b000, r);
    cyc(1, 8'hC3, 0, 3'b000, r);
    chk("pre_arst_vld", vld3(), 3'b111);
    #2;
    RESETL = 1'b0;
    #1;
    chk("arst_vld", vld3(), 3'b000);
    chk("arst_q", {A_Q, B_Q, C_Q}, 24'h0);
    chk("arst_sel", sel2(), 2'b00);
    chk("arst_rdy", DREADY, 1'b1);
    @(negedge CLK);
    RESETL = 1'b1;
    @(posedge CLK);
    #1;

    // continuous stream with all ACKs held high
    begin
      int got = 0;
      for (int i = 0; i < 300; i++) begin
        logic [2:0] ev;
        logic [7:0] q;
        cyc(1, i[7:0], 0, 3'b111, r);
        chk($sformatf("strm%0d_rdy", i), r, 1'b1);
        ev = 3'b001 << (i % 3);
        chk($sformatf("strm%0d_vld", i), vld3(), ev);
        q = (i % 3 == 0) ? A_Q : (i % 3 == 1) ? B_Q : C_Q;
        chk($sformatf("strm%0d_q", i), q, i[7:0]);
        if (vld3() != 3'b000) got++;
      end
      chk("strm_count", got, 300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmx3_seq.md
# dmx3_seq

Three-way sequencing demultiplexer: the distributing counterpart of the counters-section three-input select mux. It accepts a single stream of W-bit words and deals them round-robin into three holding registers (channels A, B, C). Each channel presents a valid/acknowledge pair to its consumer. SEL_0/SEL_1 outputs use the same select encoding as the collecting mux, so a downstream mux can read the channels back in matching order.

## Interface
- W, 8, data width of the stream and of each channel register.
- CLK  in  1  system clock; all state changes on rising edge.
- RESETL  in  1  reset, asynchronous, active-low.
- DIN  in  W  input word.
- DVALID  in  1  DIN is valid this cycle.
- DREADY  out  1  block accepts DIN this cycle; transfer = DVALID & DREADY.
- SYNC  in  1  frame restart; forces next target pointer to channel A.
- A_Q, B_Q, C_Q  out  W  channel holding registers.
- A_VLD, B_VLD, C_VLD  out  1  channel register full.
- A_ACK, B_ACK, C_ACK  in  1  consumer has taken the channel word; clears its VLD.
- SEL_0  out  1  next target is B.
- SEL_1  out  1  next target is C; SEL_0 = SEL_1 = 0 means A; 11 never driven.

## Operation
- State: 2-bit pointer PTR ∈ {A=00, B=01, C=10}; per-channel FULL flags (= x_VLD); three W-bit registers.
- Target channel T: equals PTR (base build). SEL_1:SEL_0 = T encoding.
- DREADY = ~FULL[T]. It is combinational from registered state only; ACK inputs do not feed DREADY.
- On transfer: REG[T] <= DIN, FULL[T] <= 1, PTR <= T+1 mod 3 (C wraps to A).
- x_ACK while x_VLD = 1: FULL cleared next edge; register contents retained. ACK while x_VLD = 0: ignored.
- Transfer and ACK on different channels in the same cycle: both take effect.
- Transfer to T and ACK of T in the same cycle is impossible (DREADY was 0).
- SYNC: PTR <= A next edge. SYNC with a transfer in the same cycle: the word goes to the current T, then PTR = A. SYNC does not alter FULL flags or registers.
- PTR value 11 is unreachable. If it occurs, it is treated as A.

## Timing
- Reset (RESETL low, asynchronous): PTR = A; all FULL = 0; A_Q/B_Q/C_Q = 0; x_VLD = 0; SEL_0 = SEL_1 = 0; DREADY = 1 (combinational after reset).
- Reset asserted mid-stream: all state cleared immediately; pending words are lost.
- Latency: a word accepted at edge n appears on x_Q with x_VLD = 1 after edge n.
- ACK at edge n: x_VLD = 0 after edge n. The channel can be rewritten in cycle n+1 if it is the target.
- Throughput: one word per cycle while the target channel is empty.
- SEL outputs change only on clock edges (registered PTR/FULL path).

## Configuration
- DMX3_SKIP_BUSY_EN
  - Undefined: strict round-robin; stalls (DREADY = 0) while channel PTR is full, even if other channels are free.
  - Defined: T = first channel with FULL = 0 searching PTR, PTR+1, PTR+2 (mod 3). DREADY = ~(A_VLD & B_VLD & C_VLD). On transfer, PTR <= T+1 mod 3. SEL reflects the searched T. SYNC still forces PTR = A, and the search then starts from A.

## Test plan
- Reset, then DIN = 0x11, 0x22, 0x33 on three consecutive DVALID cycles with no ACK -> A_Q = 0x11, B_Q = 0x22, C_Q = 0x33, all VLD = 1; then DREADY = 0; SEL = 00.
- From the full state, B_ACK pulse then DIN = 0x44 -> base build: DREADY stays 0 (target A is full) until A_ACK, then A_Q = 0x44. With DMX3_SKIP_BUSY_EN: B_Q = 0x44 the cycle after B_ACK.
- Write 0x55 to A, assert SYNC on the cycle that writes 0x66 -> 0x66 lands in B, next word 0x77 lands in A, SEL = 00 after the SYNC edge.
- Fill C while asserting A_ACK in the same cycle -> C_VLD = 1 and A_VLD = 0 after that edge; PTR wraps to A.
- Drop RESETL asynchronously mid-cycle with all channels full -> all VLD, Q, and SEL outputs go to 0 without a clock edge; DREADY = 1.
- Continuous stream of 300 words with ACK on every channel each cycle -> one word per cycle, order A, B, C repeating, no word lost or duplicated (scoreboard check).
